// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants: receiver state encoding and bit period.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 10417;

    typedef logic [2:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t START = 3'd1;
    localparam state_t DATA  = 3'd2;
    localparam state_t STOP  = 3'd3;
    localparam state_t BREAK = 3'd4;

endpackage

`default_nettype wire

// File: rtl/rx_sync.sv
// ============================================================================
// Module      : rx_sync
// Description : Two-flop synchronizer for the serial input, preset to idle-high.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_sync (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Preset to 1 so reset release never looks like a start edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : 8N1 serial receiver, LSB first, mid-bit sampling, break hold-off.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RXD,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    output logic       RX_BUSY,
    output logic       RX_ERR
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] C_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_HALF_LAST = CW'(HALF_BIT - 1);

    logic          rxd_s;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;

    rx_sync u_sync (
        .CLK (CLK),
        .RST (RST),
        .d   (RXD),
        .q   (rxd_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxd_s) state_d = START;
            end
            START: begin
                if (cnt_q == C_HALF_LAST) begin
                    cnt_d = '0;
                    idx_d = 3'd0;
                    // A line back high at mid-start was a glitch, not a frame.
                    state_d = rxd_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == C_BIT_LAST) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = rxd_s;
                    if (idx_q == 3'd7) state_d = STOP;
                    else               idx_d   = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == C_BIT_LAST) begin
                    cnt_d = '0;
                    if (rxd_s) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rxd_s) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Busy follows the next state so it drops together with the valid strobe.
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shreg_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign RX_DATA  = data_q;
    assign RX_VALID = valid_q;
    assign RX_BUSY  = busy_q;
    assign RX_ERR   = err_q;

endmodule

`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver: 8N1 frames, LSB first, idle-high line.
- It is the far end of the tx module's TXD line. It recovers the byte that tx shifted out from SWIn.
- Sits between the external RXD pin and the display/consumer logic. It presents each received byte with a one-cycle valid strobe.
- Must decode tx output directly when both run at the same bit period.

Parameters:
CLKS_PER_BIT, 10417, CLK cycles per serial bit (100 MHz / 9600 baud); must be >= 4.
HALF_BIT, CLKS_PER_BIT/2, mid-bit sample offset (derived, not overridable).

Ports:
CLK  input  1  system clock, rising-edge.
RST  input  1  asynchronous, active-high reset.
RXD  input  1  serial line in, asynchronous to CLK, idle high.
RX_DATA  output  8  last received byte; held until the next frame completes.
RX_VALID  output  1  one-cycle pulse; RX_DATA is new and the stop bit was good.
RX_BUSY  output  1  high from start-edge detection until the frame ends or is rejected.
RX_ERR  output  1  one-cycle pulse on a framing error (stop bit sampled low).

Behaviour:
- Reset (async, RST=1):
  - RX_DATA=8'h00; RX_VALID=0; RX_BUSY=0; RX_ERR=0.
  - State=IDLE; counters=0; synchronizer flops=1.
- Input sync: RXD passes through 2 flops (rxd_s). All decisions use rxd_s. Fixed latency is 2 CLK.
- Bit counter (cnt) counts 0..CLKS_PER_BIT-1 and wraps to 0. Bit index (idx) is 0..7.
- FSM states:
  - IDLE:
    - RX_BUSY=0.
    - rxd_s==0 -> START, cnt=0, RX_BUSY=1 on the next cycle.
  - START:
    - When cnt==HALF_BIT-1, sample rxd_s.
    - If rxd_s==0 -> DATA, cnt=0, idx=0.
    - If rxd_s==1 -> glitch: IDLE, RX_BUSY=0, no strobes.
  - DATA:
    - When cnt==CLKS_PER_BIT-1 (the mid-bit point), shift rxd_s into shreg[idx], LSB first.
    - If idx==7 -> STOP, else idx+1.
  - STOP:
    - When cnt==CLKS_PER_BIT-1, sample rxd_s.
    - If 1: RX_DATA<=shreg, RX_VALID=1 for one cycle -> IDLE.
    - If 0: RX_ERR=1 for one cycle, RX_DATA unchanged -> BREAK.
  - BREAK:
    - RX_BUSY=1; wait until rxd_s==1 -> IDLE.
    - This prevents a held-low line (break) from retriggering frames.
- Return to IDLE at mid-stop-bit. A following start bit that begins at the end of the stop bit is caught.
- Back-to-back frames need no idle gap.
- Latency: let t0 be the first CLK edge where RXD is low. Then RX_VALID is high at edge t0 + 2 + HALF_BIT + 9*CLKS_PER_BIT (±1).
- RX_VALID and RX_ERR are mutually exclusive, never high together.
- RX_BUSY falls in the same cycle RX_VALID rises.
- RST asserted mid-frame: immediate return to reset values. The partial byte is discarded and no strobe fires.
- After RST release with RXD held low: the FSM enters START and rejects or accepts normally. No requirement beyond that.
- No parity, no FIFO, no overrun detection. The consumer must take RX_DATA within one frame time.

Decomposition:
- Shared package (uart_pkg): FSM state encoding localparams (IDLE, START, DATA, STOP, BREAK, 3-bit) and DEFAULT_CLKS_PER_BIT. tx uses the same package for its bit-period constant.
- One sub-module: rx_sync, a 2-flop synchronizer. Async RST presets both flops to 1 so there is no false start at reset release.
- Counter and FSM stay in uart_rx.

Test Plan (CLKS_PER_BIT=10, CLK period 10 ns):
- Drive frame 0xAC (start, bits 0,0,1,1,0,1,0,1, stop) -> one RX_VALID pulse, RX_DATA=8'hAC, RX_ERR never high, RX_BUSY high ~95 cycles.
- Frame 0xAC immediately followed by 0xDC with no idle gap -> two RX_VALID pulses ~100 cycles apart, RX_DATA 8'hAC then 8'hDC.
- 30 ns low glitch on idle RXD -> RX_BUSY pulses for ~5 cycles, no RX_VALID/RX_ERR, RX_DATA unchanged.
- Frame 0x55 with stop bit driven low, line held low 300 ns then high -> RX_ERR pulse once, RX_DATA keeps previous value, RX_BUSY stays high until line high, then IDLE.
- RST pulsed during bit 4 of frame 0xFF, then clean frame 0x3C -> outputs at reset values immediately, no strobe for 0xFF, then RX_DATA=8'h3C with RX_VALID.
- Loopback: tx TXD wired to RXD with matching bit period; Start with SWIn=8'hAC, then 8'hDC -> RX_DATA equals SWIn each time, one RX_VALID per tx frame.
